fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; the producer side of the fetch-to-decode pipeline register. Owns the PC,
//  reads instruction memory, and predicts branches with an 8-entry 2-bit BHT plus BTB.
//  Drives PC_curr, PC_next, inst, predicted_taken into the IF/ID register.
//  Takes branch resolution and redirect back from decode.
// PARAMETERS
//  BHT_ENTRIES  8       predictor entries; index = PC[3:1], power of two, <=8
//  RESET_PC     16'h0   PC loaded on reset
// PORTS
//  clk              in   1   system clock
//  rst              in   1   reset, synchronous, active-high
//  stall            in   1   hazard unit: hold PC and predictor reads
//  mispredicted     in   1   decode: resolved branch disagrees with prediction; redirect
//  actual_target    in   16  decode: correct next PC when mispredicted
//  update_en        in   1   decode: a branch resolved this cycle; train predictor
//  update_pc_low    in   4   decode: pipelined PC[3:0] of the resolved branch
//  actual_taken     in   1   decode: resolved direction
//  branch_target    in   16  decode: computed target of the resolved branch
//  imem_addr        out  16  instruction memory address (= PC_curr)
//  imem_rdata       in   16  instruction word; combinational read of imem_addr
//  PC_curr          out  16  current PC
//  PC_next          out  16  PC_curr + 2, sequential successor
//  PC_inst          out  16  fetched instruction word (= imem_rdata)
//  predicted_taken  out  1   BHT/BTB prediction for PC_curr
//  halted           out  1   HLT fetched and latched; PC frozen
// BEHAVIOUR
//  - PC register is the only PC state. Reset: PC=RESET_PC, halted=0, all counters=WEAK_NT (2'b01), all BTB valid=0.
//  - Prediction (combinational, same cycle): idx=PC_curr[3:1]; predicted_taken = cnt[idx][1] & btb_valid[idx].
//  - Next PC priority, highest first:
//    rst -> RESET_PC; mispredicted -> actual_target, and halted clears (this also overrides stall);
//    halted -> hold; stall -> hold; predicted_taken -> btb_target[idx]; else PC_curr+2.
//  - PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000, no flag. Bit 0 of the PC is never forced.
//  - Halt: when inst[15:12]==HLT_OPCODE (4'hF), ~stall and ~mispredicted, halted sets at the next edge.
//    Once set, the PC freezes on the HLT address and HLT is re-presented every cycle.
//    Only rst or mispredicted clears halted.
//  - Training on update_en, at the edge, with u=update_pc_low[3:1]:
//    actual_taken -> cnt[u] increments, saturating at 2'b11; btb_target[u]=branch_target; btb_valid[u]=1.
//    not taken -> cnt[u] decrements, saturating at 2'b00; BTB entry unchanged.
//  - Training is independent of stall and halted; it happens even while stalled.
//  - Same-index read/write in one cycle: prediction uses the pre-edge value; the new value is visible next cycle.
//  - Latency: a redirect takes effect on the next cycle's PC_curr. A training update is visible to the next prediction.
//  - rst asserted mid-stall or mid-halt: the reset values above apply at that edge; no stale state survives.
// CONFIGURATION
//  FETCH_BPRED_EN defined: BHT/BTB as above.
//  FETCH_BPRED_EN undefined: no predictor storage; predicted_taken=0 always; next PC = PC_curr+2 unless
//   mispredicted/halted/stall. The update_* and branch_target inputs are ignored and left unused.
// STRUCTURE
//  fetch_pkg: pc_t (logic [15:0]); bht_cnt_e {STRONG_NT=2'b00, WEAK_NT, WEAK_T, STRONG_T};
//   HLT_OPCODE=4'hF; BHT_IDX_W=$clog2(BHT_ENTRIES); PC_INCR=16'd2.
//  Sub-module branch_predictor_2bit: counter array, BTB and valid bits, read port (idx) and
//   train port (u, taken, target). Instantiated only under FETCH_BPRED_EN.
//  The top level holds the PC register, halt flag and next-PC mux.
// TESTING
//  1 Reset, then run with imem of NOPs -> PC 0,2,4,6...; PC_next=PC+2; predicted_taken=0; halted=0.
//  2 update_en with pc_low=4'h4, taken=1, target=16'h0040, applied twice -> cnt[2]=STRONG_T;
//    on the next fetch at 16'h0014: predicted_taken=1 and the following PC=16'h0040.
//  3 From STRONG_T, three not-taken updates -> counter steps 11->10->01->00 and stays 00 on a fourth;
//    predicted_taken=0 from the second update on.
//  4 stall=1 and mispredicted=1 together with actual_target=16'h0100 -> PC_curr=16'h0100 next cycle.
//    stall=1 alone -> PC holds for 3 cycles exactly.
//  5 imem returns 16'hF000 at 16'h0020 -> halted=1 and PC stays 16'h0020; mispredicted with target
//    16'h0030 -> halted=0, PC=16'h0030.
//  6 PC=16'hFFFE with no prediction -> PC=16'h0000. Build without FETCH_BPRED_EN, repeat case 2 ->
//    predicted_taken stays 0 and PC is sequential.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef logic [15:0] pc_t;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bht_cnt_e;

   localparam logic [3:0] HLT_OPCODE      = 4'hF;
   localparam int         BHT_ENTRIES_DEF = 8;
   localparam int         BHT_IDX_W       = $clog2(BHT_ENTRIES_DEF);
   localparam pc_t        PC_INCR         = 16'd2;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic bht_cnt_e cnt_train(input bht_cnt_e c, input logic taken);
      logic [1:0] v;
      v = c;
      if (taken) begin
         if (v != 2'b11) v = v + 2'd1;
      end else begin
         if (v != 2'b00) v = v - 2'd1;
      end
      return bht_cnt_e'(v);
   endfunction

endpackage

// File: rtl/branch_predictor_2bit.sv
// 2-bit saturating-counter BHT with a direct-mapped BTB.
// Read port is combinational; the train port writes at the clock edge, so a
// same-index read in the training cycle still returns the old entry.
module branch_predictor_2bit
   import fetch_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   output pc_t              rd_target_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i,
   input  pc_t              wr_target_i
);

   bht_cnt_e             cnt_q [ENTRIES];
   logic [ENTRIES-1:0]   valid_q;
   pc_t                  tgt_q [ENTRIES];

   // Only a valid BTB entry with a taken-leaning counter predicts taken.
   always_comb begin
      rd_taken_o  = cnt_q[rd_idx_i][1] & valid_q[rd_idx_i];
      rd_target_o = tgt_q[rd_idx_i];
   end

   // Counter and valid-bit training; reset returns every entry to weak not-taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WEAK_NT;
         valid_q <= '0;
      end else if (wr_en_i) begin
         cnt_q[wr_idx_i] <= cnt_train(cnt_q[wr_idx_i], wr_taken_i);
         if (wr_taken_i) valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Target storage is gated by its valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_en_i && wr_taken_i) tgt_q[wr_idx_i] <= wr_target_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, halt flag and next-PC selection.
// Optional feature macro: FETCH_BPRED_EN enables the BHT/BTB predictor;
// without it the fetch is purely sequential and the training inputs are unused.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int  BHT_ENTRIES = 8,
   parameter pc_t RESET_PC    = 16'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        mispredicted,
   input  logic [15:0] actual_target,
   input  logic        update_en,
   input  logic [3:0]  update_pc_low,
   input  logic        actual_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   output logic [15:0] PC_curr,
   output logic [15:0] PC_next,
   output logic [15:0] PC_inst,
   output logic        predicted_taken,
   output logic        halted
);

   pc_t  pc_q, pc_d;
   logic halted_q, halted_d;
   logic pred_taken;
   pc_t  pred_target;
   logic hlt_fetch;

`ifdef FETCH_BPRED_EN
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic unused_ok;
   assign unused_ok = update_pc_low[0];

   branch_predictor_2bit #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bpred (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (pc_q[IDX_W:1]),
      .rd_taken_o  (pred_taken),
      .rd_target_o (pred_target),
      .wr_en_i     (update_en),
      .wr_idx_i    (update_pc_low[IDX_W:1]),
      .wr_taken_i  (actual_taken),
      .wr_target_i (branch_target)
   );
`else
   localparam int unused_entries = BHT_ENTRIES;

   logic unused_ok;
   assign unused_ok   = ^{update_en, update_pc_low, actual_taken, branch_target};
   assign pred_taken  = 1'b0;
   assign pred_target = '0;
`endif

   assign hlt_fetch = (imem_rdata[15:12] == HLT_OPCODE);

   // Next PC: redirect beats everything (and un-halts); a fresh HLT freezes on its own address.
   always_comb begin
      pc_d     = pc_q + PC_INCR;
      halted_d = halted_q;
      if (mispredicted) begin
         pc_d     = actual_target;
         halted_d = 1'b0;
      end else if (halted_q || stall) begin
         pc_d = pc_q;
      end else if (hlt_fetch) begin
         pc_d     = pc_q;
         halted_d = 1'b1;
      end else if (pred_taken) begin
         pc_d = pred_target;
      end
   end

   // PC and halt state; synchronous reset wins over stall and halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   assign imem_addr       = pc_q;
   assign PC_curr         = pc_q;
   assign PC_next         = pc_q + PC_INCR;
   assign PC_inst         = imem_rdata;
   assign predicted_taken = pred_taken;
   assign halted          = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch state,
// a negedge monitor pops and compares. Expectations follow FETCH_BPRED_EN.
module tb_fetch_unit;

`ifdef FETCH_BPRED_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   typedef struct {
      logic [15:0] pc;
      logic        pred;
      logic        hlt;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, mispredicted, update_en, actual_taken;
   logic [15:0] actual_target, branch_target, imem_addr, imem_rdata;
   logic [3:0]  update_pc_low;
   logic [15:0] PC_curr, PC_next, PC_inst;
   logic        predicted_taken, halted;

   logic [15:0] hlt_addr;
   logic        hlt_on;
   exp_t        exp_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .mispredicted(mispredicted),
      .actual_target(actual_target), .update_en(update_en),
      .update_pc_low(update_pc_low), .actual_taken(actual_taken),
      .branch_target(branch_target), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .PC_curr(PC_curr), .PC_next(PC_next),
      .PC_inst(PC_inst), .predicted_taken(predicted_taken), .halted(halted)
   );

   always #5 clk = ~clk;

   // Instruction memory: non-HLT words carry the low address bits, HLT at hlt_addr.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (hlt_on && a == hlt_addr) return 16'hF000;
      return {4'h0, a[11:0]};
   endfunction

   always_comb imem_rdata = mem_word(imem_addr);

   // Monitor: compare the presented fetch state against the oldest expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [15:0] nx, in;
         e  = exp_q.pop_front();
         nx = e.pc + 16'd2;
         in = mem_word(e.pc);
         n_chk++;
         if (PC_curr === e.pc && imem_addr === e.pc && PC_next === nx &&
             PC_inst === in && predicted_taken === e.pred && halted === e.hlt)
            n_pass++;
         else
            $display("FAIL %s: got pc=%h next=%h inst=%h addr=%h pred=%b hlt=%b, want pc=%h next=%h inst=%h pred=%b hlt=%b",
                     e.name, PC_curr, PC_next, PC_inst, imem_addr, predicted_taken, halted,
                     e.pc, nx, in, e.pred, e.hlt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input logic [15:0] pc, input logic pred, input logic hlt, input string nm);
      exp_t e;
      e.pc = pc; e.pred = pred; e.hlt = hlt; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic redirect(input logic [15:0] t, input logic stl);
      mispredicted = 1'b1; actual_target = t; stall = stl;
      step();
      mispredicted = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; mispredicted = 1'b0; actual_target = '0;
      update_en = 1'b0; update_pc_low = '0; actual_taken = 1'b0; branch_target = '0;
      hlt_addr = 16'h0020; hlt_on = 1'b0;

      // Reset and sequential fetch
      step(); step();
      rst = 1'b0;
      expect_st(16'h0000, 1'b0, 1'b0, "reset");
      for (int i = 1; i < 4; i++) begin
         step();
         expect_st(16'(2 * i), 1'b0, 1'b0, "seq");
      end

      // Train idx 2 taken twice while stalled; training ignores stall
      stall = 1'b1; update_en = 1'b1; update_pc_low = 4'h4;
      actual_taken = 1'b1; branch_target = 16'h0040;
      step(); expect_st(16'h0006, 1'b0, 1'b0, "train_stall1");
      step(); expect_st(16'h0006, 1'b0, 1'b0, "train_stall2");
      update_en = 1'b0;
      redirect(16'h0014, 1'b0); expect_st(16'h0014, BP, 1'b0, "pred_at_14");
      step(); expect_st(BP ? 16'h0040 : 16'h0016, 1'b0, 1'b0, "pred_follow");

      // Not-taken training from STRONG_T, with saturation at 00
      redirect(16'h0014, 1'b1); expect_st(16'h0014, BP, 1'b0, "redir_over_stall");
      update_en = 1'b1; actual_taken = 1'b0;
      step(); expect_st(16'h0014, BP,   1'b0, "nt1_10");
      step(); expect_st(16'h0014, 1'b0, 1'b0, "nt2_01");
      step(); expect_st(16'h0014, 1'b0, 1'b0, "nt3_00");
      step(); expect_st(16'h0014, 1'b0, 1'b0, "nt4_sat00");
      actual_taken = 1'b1;
      step(); expect_st(16'h0014, 1'b0, 1'b0, "t_00_01");
      step(); expect_st(16'h0014, BP,   1'b0, "t_01_10");
      update_en = 1'b0;

      // Redirect with stall, then stall alone holds exactly 3 cycles
      redirect(16'h0100, 1'b1); expect_st(16'h0100, 1'b0, 1'b0, "stall_mispred");
      for (int i = 0; i < 3; i++) begin
         step(); expect_st(16'h0100, 1'b0, 1'b0, "stall_hold");
      end
      stall = 1'b0;
      step(); expect_st(16'h0102, 1'b0, 1'b0, "stall_release");

      // Halt at 0x20, then redirect out of it
      hlt_on = 1'b1;
      redirect(16'h001C, 1'b0); expect_st(16'h001C, 1'b0, 1'b0, "pre_hlt0");
      step(); expect_st(16'h001E, 1'b0, 1'b0, "pre_hlt1");
      step(); expect_st(16'h0020, 1'b0, 1'b0, "hlt_fetch");
      step(); expect_st(16'h0020, 1'b0, 1'b1, "halted1");
      step(); expect_st(16'h0020, 1'b0, 1'b1, "halted2");
      redirect(16'h0030, 1'b0); expect_st(16'h0030, 1'b0, 1'b0, "unhalt");
      hlt_on = 1'b0;

      // Reset mid-stall clears PC and predictor state
      stall = 1'b1; rst = 1'b1;
      step(); expect_st(16'h0000, 1'b0, 1'b0, "rst_mid_stall");
      rst = 1'b0; stall = 1'b0;
      redirect(16'h0014, 1'b0); expect_st(16'h0014, 1'b0, 1'b0, "bht_cleared");

      // PC wrap
      redirect(16'hFFFC, 1'b0); expect_st(16'hFFFC, 1'b0, 1'b0, "wrap0");
      step(); expect_st(16'hFFFE, 1'b0, 1'b0, "wrap1");
      step(); expect_st(16'h0000, 1'b0, 1'b0, "wrap2");

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
      if (exp_q.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
